icache_fetch_responder: RTL and testbench

- Direct-mapped instruction cache that answers the program counter's fetch requests.
- Takes the 32-bit PC each cycle and returns INSTRUCTION on a hit.
- On a miss, raises BUSYWAIT so the PC and pipeline stall, then refills one 4-word block from instruction memory over a MEM_READ / MEM_BUSYWAIT handshake.
- Sits between the PC register and the instruction memory.

---
 rtl/icache_fetch_responder.sv | 132 +++++++++++++
 tb/tb_icache_fetch_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache between the PC unit and instruction memory.
// Hits return a word in the same cycle; a miss stalls the pipeline and refills one 4-word block.
module icache_fetch_responder #(
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned TAG_BITS   = 3
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [31:0]                    PC,
  output logic [31:0]                    INSTRUCTION,
  output logic                           BUSYWAIT,
  output logic                           MEM_READ,
  output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
  input  logic [127:0]                   MEM_READDATA,
  input  logic                           MEM_BUSYWAIT
);

  localparam int unsigned ADDR_BITS  = TAG_BITS + INDEX_BITS;
  localparam int unsigned NUM_BLOCKS = 1 << INDEX_BITS;
  localparam int unsigned BLOCK_BITS = 128;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_BLOCKS-1:0]   valid_q, valid_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [BLOCK_BITS-1:0]   refill_q, refill_d;
  logic [TAG_BITS-1:0]     tag_q  [NUM_BLOCKS];
  logic [BLOCK_BITS-1:0]   data_q [NUM_BLOCKS];

  logic [INDEX_BITS-1:0]   pc_index;
  logic [TAG_BITS-1:0]     pc_tag;
  logic [1:0]              pc_offset;
  logic [INDEX_BITS-1:0]   upd_index;
  logic [TAG_BITS-1:0]     upd_tag;
  logic [BLOCK_BITS-1:0]   rd_block;
  logic                    hit;
  logic                    blk_wr_en;
  logic                    unused_pc;

  assign pc_offset = PC[3:2];
  assign pc_index  = PC[INDEX_BITS+3:4];
  assign pc_tag    = PC[ADDR_BITS+3:INDEX_BITS+4];
  assign unused_pc = ^{PC[31:ADDR_BITS+4], PC[1:0]};

  assign upd_index = addr_q[INDEX_BITS-1:0];
  assign upd_tag   = addr_q[ADDR_BITS-1:INDEX_BITS];

  assign rd_block  = data_q[pc_index];
  assign hit       = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);

  assign MEM_ADDRESS = addr_q;

  // State register and control flops; reset abandons any refill in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      valid_q  <= '0;
      addr_q   <= '0;
      refill_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      refill_q <= refill_d;
    end
  end

  // Tag and data storage need no reset: valid bits guard every read.
  always_ff @(posedge CLK) begin
    if (blk_wr_en) begin
      tag_q[upd_index]  <= upd_tag;
      data_q[upd_index] <= refill_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    refill_d  = refill_q;
    blk_wr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!hit) begin
          addr_d  = {pc_tag, pc_index};
          state_d = ST_MEM_READ;
        end
      end
      ST_MEM_READ: begin
        if (!MEM_BUSYWAIT) begin
          refill_d = MEM_READDATA;
          state_d  = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        blk_wr_en          = 1'b1;
        valid_d[upd_index] = 1'b1;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; the stall is held low during reset so an empty cache does not stall the PC.
  always_comb begin
    BUSYWAIT    = 1'b1;
    MEM_READ    = 1'b0;
    INSTRUCTION = '0;
    case (state_q)
      ST_IDLE: begin
        BUSYWAIT = RESET && !hit;
        if (hit) begin
          case (pc_offset)
            2'd0:    INSTRUCTION = rd_block[31:0];
            2'd1:    INSTRUCTION = rd_block[63:32];
            2'd2:    INSTRUCTION = rd_block[95:64];
            default: INSTRUCTION = rd_block[127:96];
          endcase
        end
      end
      ST_MEM_READ: MEM_READ = 1'b1;
      default:     MEM_READ = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Scoreboard bench for icache_fetch_responder with a behavioural instruction memory.
module tb_icache_fetch_responder;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int          busy_cycles = 0;
  int          mem_cnt     = 0;
  logic [31:0] sb_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;

  icache_fetch_responder #(.INDEX_BITS(3), .TAG_BITS(3)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Each memory word holds its own byte address.
  function automatic logic [127:0] mem_block(input logic [5:0] addr);
    logic [127:0] blk;
    for (int i = 0; i < 4; i++) blk[i*32 +: 32] = {22'd0, addr, i[1:0], 2'b00};
    return blk;
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return pc & 32'h0000_03FC;
  endfunction

  // Memory: busy for busy_cycles cycles of a read, then data valid.
  always @(posedge CLK) begin
    #1;
    if (MEM_READ) begin
      if (mem_cnt < busy_cycles) begin
        MEM_BUSYWAIT = 1'b1;
        mem_cnt++;
      end else begin
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = mem_block(MEM_ADDRESS);
      end
    end else begin
      mem_cnt      = 0;
      MEM_BUSYWAIT = 1'b1;
    end
  end

  // Drive a PC (call just after a rising edge) and wait for BUSYWAIT to drop.
  task automatic run_fetch(input logic [31:0] pc, output logic [31:0] instr, output int stall,
                           output int mcyc, output logic [5:0] addr, output bit to);
    PC = pc;
    sb_q.push_back(exp_instr(pc));
    stall = 0; mcyc = 0; addr = 6'h3F; to = 1'b1; instr = 'x;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (MEM_READ) begin
        mcyc++;
        addr = MEM_ADDRESS;
      end
      if (!BUSYWAIT) begin
        instr = INSTRUCTION;
        to    = 1'b0;
        break;
      end
      stall++;
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0; PC = 32'h0; MEM_BUSYWAIT = 1'b1; MEM_READDATA = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    tests_run++;
    if (BUSYWAIT !== 1'b0) begin tests_failed++; $display("FAIL reset_busywait got=%b exp=0", BUSYWAIT); end
    tests_run++;
    if (MEM_READ !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_read got=%b exp=0", MEM_READ); end
    tests_run++;
    if (MEM_ADDRESS !== 6'd0) begin tests_failed++; $display("FAIL reset_mem_address got=%0d exp=0", MEM_ADDRESS); end
    tests_run++;
    if (INSTRUCTION !== 32'h0) begin tests_failed++; $display("FAIL reset_instruction got=%h exp=0", INSTRUCTION); end
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    tests_run++;
    if (BUSYWAIT !== 1'b1) begin tests_failed++; $display("FAIL post_reset_miss busywait got=%b exp=1", BUSYWAIT); end
  endtask

  task automatic test_cold_miss();
    logic [31:0] instr, exp; int stall, mcyc; logic [5:0] addr; bit to;
    busy_cycles = 4;
    run_fetch(32'h000, instr, stall, mcyc, addr, to);
    exp = sb_q.pop_front();
    tests_run++;
    if (to || instr !== exp) begin tests_failed++; $display("FAIL cold_instr got=%h exp=%h timeout=%0d", instr, exp, to); end
    tests_run++;
    if (mcyc != 5) begin tests_failed++; $display("FAIL cold_mem_read_cycles got=%0d exp=5", mcyc); end
    tests_run++;
    if (addr !== 6'd0) begin tests_failed++; $display("FAIL cold_mem_address got=%0d exp=0", addr); end
    tests_run++;
    if (stall != 7) begin tests_failed++; $display("FAIL cold_stall_cycles got=%0d exp=7", stall); end
  endtask

  task automatic test_hits();
    logic [31:0] instr, exp; int stall, mcyc; logic [5:0] addr; bit to;
    for (int i = 1; i < 4; i++) begin
      run_fetch(32'(4 * i), instr, stall, mcyc, addr, to);
      exp = sb_q.pop_front();
      tests_run++;
      if (to || instr !== exp) begin tests_failed++; $display("FAIL hit_instr[%0d] got=%h exp=%h timeout=%0d", i, instr, exp, to); end
      tests_run++;
      if (stall != 0) begin tests_failed++; $display("FAIL hit_stall[%0d] got=%0d exp=0", i, stall); end
      tests_run++;
      if (mcyc != 0) begin tests_failed++; $display("FAIL hit_mem_read[%0d] got=%0d exp=0", i, mcyc); end
    end
  endtask

  task automatic test_conflict();
    logic [31:0] instr, exp; int stall, mcyc; logic [5:0] addr; bit to;
    busy_cycles = 1;
    run_fetch(32'h080, instr, stall, mcyc, addr, to);
    exp = sb_q.pop_front();
    tests_run++;
    if (to || instr !== exp) begin tests_failed++; $display("FAIL conflict_instr got=%h exp=%h timeout=%0d", instr, exp, to); end
    tests_run++;
    if (addr !== 6'd8) begin tests_failed++; $display("FAIL conflict_mem_address got=%0d exp=8", addr); end
    tests_run++;
    if (stall != 4) begin tests_failed++; $display("FAIL conflict_stall got=%0d exp=4", stall); end
    run_fetch(32'h000, instr, stall, mcyc, addr, to);
    exp = sb_q.pop_front();
    tests_run++;
    if (to || instr !== exp) begin tests_failed++; $display("FAIL evict_instr got=%h exp=%h timeout=%0d", instr, exp, to); end
    tests_run++;
    if (mcyc == 0 || addr !== 6'd0) begin tests_failed++; $display("FAIL evict_refetch mem_cycles=%0d addr=%0d exp_addr=0", mcyc, addr); end
  endtask

  task automatic test_pc_change();
    logic [31:0] instr, exp; int stall, mcyc; logic [5:0] addr; bit to;
    int a1, a2, aoth; bit seen, done;
    busy_cycles = 3; a1 = 0; a2 = 0; aoth = 0; seen = 0; done = 0; instr = 'x;
    PC = 32'h010;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (MEM_READ) begin
        seen = 1;
        if (MEM_ADDRESS == 6'd1) a1++; else aoth++;
      end
      @(posedge CLK); #1;
    end
    PC = 32'h020;
    sb_q.push_back(exp_instr(32'h020));
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (MEM_READ) begin
        if (MEM_ADDRESS == 6'd1) a1++;
        else if (MEM_ADDRESS == 6'd2) a2++;
        else aoth++;
      end
      if (!BUSYWAIT) begin instr = INSTRUCTION; done = 1; end
      @(posedge CLK); #1;
    end
    exp = sb_q.pop_front();
    tests_run++;
    if (!done || instr !== exp) begin tests_failed++; $display("FAIL pcchg_instr got=%h exp=%h done=%0d", instr, exp, done); end
    tests_run++;
    if (a1 != 4 || a2 != 4 || aoth != 0) begin
      tests_failed++; $display("FAIL pcchg_addr_cycles a1=%0d a2=%0d other=%0d exp=4/4/0", a1, a2, aoth);
    end
    run_fetch(32'h014, instr, stall, mcyc, addr, to);
    exp = sb_q.pop_front();
    tests_run++;
    if (to || instr !== exp || stall != 0) begin
      tests_failed++; $display("FAIL pcchg_block1_hit got=%h exp=%h stall=%0d", instr, exp, stall);
    end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] instr, exp; int stall, mcyc; logic [5:0] addr; bit to, seen;
    run_fetch(32'h004, instr, stall, mcyc, addr, to);
    exp = sb_q.pop_front();
    tests_run++;
    if (to || instr !== exp || stall != 0) begin
      tests_failed++; $display("FAIL prerst_hit got=%h exp=%h stall=%0d", instr, exp, stall);
    end
    busy_cycles = 5; seen = 0;
    PC = 32'h040;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (MEM_READ) seen = 1;
      else begin @(posedge CLK); #1; end
    end
    #2;
    RESET = 1'b0;
    #1;
    tests_run++;
    if (!seen || MEM_READ !== 1'b0) begin tests_failed++; $display("FAIL midrst_mem_read got=%b exp=0 seen=%0d", MEM_READ, seen); end
    tests_run++;
    if (BUSYWAIT !== 1'b0) begin tests_failed++; $display("FAIL midrst_busywait got=%b exp=0", BUSYWAIT); end
    @(posedge CLK); #1;
    RESET = 1'b1;
    busy_cycles = 0;
    run_fetch(32'h004, instr, stall, mcyc, addr, to);
    exp = sb_q.pop_front();
    tests_run++;
    if (to || instr !== exp) begin tests_failed++; $display("FAIL postrst_instr got=%h exp=%h timeout=%0d", instr, exp, to); end
    tests_run++;
    if (mcyc != 1 || addr !== 6'd0) begin tests_failed++; $display("FAIL postrst_refetch mem_cycles=%0d addr=%0d exp=1/0", mcyc, addr); end
    tests_run++;
    if (stall != 3) begin tests_failed++; $display("FAIL postrst_stall got=%0d exp=3", stall); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_pc_change();
    test_reset_mid_refill();
    tests_run++;
    if (sb_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
